// File: rtl/step_sequencer_pkg.sv
// Shared constants for the step sequencer: state encodings, fault causes
// and default sizing. Lives alongside the decoder constants.
package step_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_HALTED = 2'd2,
      ST_FAULT  = 2'd3
   } seq_state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b01;
   localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;

   localparam int DEF_MAX_T      = 3;
   localparam int DEF_WAIT_LIMIT = 15;

   // Step index following t.
   function automatic logic [2:0] next_step(input logic [2:0] t);
      return t + 3'd1;
   endfunction

endpackage

// File: rtl/step_sequencer_wait_timer.sv
// Counts cycles of an unacknowledged memory request and flags the cycle in
// which the request has waited WAIT_LIMIT cycles without an ack.
module wait_timer
   import step_sequencer_pkg::*;
#(
   parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

   logic [CW-1:0] wait_cnt_r;
   logic          at_limit_s;

   assign at_limit_s = (wait_cnt_r == LIMIT);
   assign expired    = active & at_limit_s;

   // Wait counter: cleared by reset or commit, saturates at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r <= '0;
      end else if (clear) begin
         wait_cnt_r <= '0;
      end else if (active && !at_limit_s) begin
         wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

endmodule

// File: rtl/step_sequencer.sv
// Microcode step counter for the multi-cycle RV32 core. Advances T on each
// committed step, stalls on memory, and handles halt, debug single-step and
// fault trapping (memory timeout, step overflow).
module step_sequencer
   import step_sequencer_pkg::*;
#(
   parameter int MAX_T      = DEF_MAX_T,
   parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        T_rst,
   input  logic        hlt,
   input  logic        mem_access,
   input  logic        mem_ack,
   input  logic        step_mode,
   input  logic        step_go,
   output logic [2:0]  T,
   output logic        commit,
   output logic        mem_req,
   output logic        paused,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] instret
);

   localparam logic [2:0] LAST_T = 3'(MAX_T - 1);

   seq_state_t  state_r, state_nxt_s;
   logic [2:0]  t_r, t_nxt_s;
   logic [31:0] instret_r, instret_nxt_s;
   logic [1:0]  cause_r, cause_nxt_s;
   logic        paused_r, halted_r, fault_r;
   logic        run_s, commit_s, mem_req_s;
   logic        wait_active_s, wait_clear_s, expired_s;

   // Commit and request are combinational so a same-cycle ack commits at once.
   assign run_s         = (state_r == ST_RUN) & ~rst;
   assign mem_req_s     = run_s & mem_access;
   assign commit_s      = run_s & (~mem_access | mem_ack);
   assign wait_active_s = mem_req_s & ~mem_ack;
   assign wait_clear_s  = commit_s | (state_r != ST_RUN);

   wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .active  (wait_active_s),
      .clear   (wait_clear_s),
      .expired (expired_s)
   );

   // Next state, step index, retire count and fault cause.
   always_comb begin
      state_nxt_s   = state_r;
      t_nxt_s       = t_r;
      instret_nxt_s = instret_r;
      cause_nxt_s   = cause_r;
      case (state_r)
         ST_RUN: begin
            if (commit_s) begin
               if (hlt) begin
                  state_nxt_s   = ST_HALTED;
                  t_nxt_s       = 3'd0;
                  instret_nxt_s = instret_r + 32'd1;
               end else if (T_rst) begin
                  state_nxt_s   = step_mode ? ST_PAUSED : ST_RUN;
                  t_nxt_s       = 3'd0;
                  instret_nxt_s = instret_r + 32'd1;
               end else if (t_r == LAST_T) begin
                  state_nxt_s = ST_FAULT;
                  cause_nxt_s = CAUSE_OVERFLOW;
               end else begin
                  t_nxt_s = next_step(t_r);
               end
            end else if (expired_s) begin
               state_nxt_s = ST_FAULT;
               cause_nxt_s = CAUSE_TIMEOUT;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_PAUSED: begin
            t_nxt_s = 3'd0;
            if (step_go || !step_mode) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_PAUSED;
            end
         end
         ST_HALTED: state_nxt_s = ST_HALTED;
         ST_FAULT:  state_nxt_s = ST_FAULT;
         default: begin
            state_nxt_s = ST_FAULT;
            cause_nxt_s = CAUSE_NONE;
         end
      endcase
   end

   // State, step index, counters and registered flag decodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_RUN;
         t_r       <= 3'd0;
         instret_r <= 32'd0;
         cause_r   <= CAUSE_NONE;
         paused_r  <= 1'b0;
         halted_r  <= 1'b0;
         fault_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         t_r       <= t_nxt_s;
         instret_r <= instret_nxt_s;
         cause_r   <= cause_nxt_s;
         paused_r  <= (state_nxt_s == ST_PAUSED);
         halted_r  <= (state_nxt_s == ST_HALTED);
         fault_r   <= (state_nxt_s == ST_FAULT);
      end
   end

   assign T           = t_r;
   assign commit      = commit_s;
   assign mem_req     = mem_req_s;
   assign paused      = paused_r;
   assign halted      = halted_r;
   assign fault       = fault_r;
   assign fault_cause = cause_r;
   assign instret     = instret_r;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with default MAX_T=3, WAIT_LIMIT=15.
module tb_step_sequencer;

   logic        clk = 1'b0;
   logic        rst, T_rst, hlt, mem_access, mem_ack, step_mode, step_go;
   logic [2:0]  T;
   logic        commit, mem_req, paused, halted, fault;
   logic [1:0]  fault_cause;
   logic [31:0] instret;

   int vectors    = 0;
   int miscompares = 0;

   step_sequencer dut (
      .clk(clk), .rst(rst), .T_rst(T_rst), .hlt(hlt),
      .mem_access(mem_access), .mem_ack(mem_ack),
      .step_mode(step_mode), .step_go(step_go),
      .T(T), .commit(commit), .mem_req(mem_req),
      .paused(paused), .halted(halted), .fault(fault),
      .fault_cause(fault_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, land 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic acc, input logic ack, input logic trst, input logic h);
      mem_access = acc;
      mem_ack    = ack;
      T_rst      = trst;
      hlt        = h;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_commit", 32'(commit), 32'd0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; T_rst = 1'b0; hlt = 1'b0; mem_access = 1'b0; mem_ack = 1'b0;
      step_mode = 1'b0; step_go = 1'b0;
      tick();
      do_reset();
      check("reset_T", 32'(T), 32'd0);
      check("reset_instret", instret, 32'd0);
      check("reset_flags", {29'd0, paused, halted, fault}, 32'd0);
      check("reset_cause", 32'(fault_cause), 32'd0);

      // ALU instruction, zero-wait fetch at T0, T_rst at T1.
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("alu_t0_req", 32'(mem_req), 32'd1);
      check("alu_t0_commit", 32'(commit), 32'd1);
      tick();
      check("alu_T1", 32'(T), 32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check("alu_t1_commit", 32'(commit), 32'd1);
      tick();
      check("alu_T0", 32'(T), 32'd0);
      check("alu_instret", instret, 32'd1);

      // Load with 3-cycle wait at T2.
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check("ld_T2", 32'(T), 32'd2);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("ld_wait_req", 32'(mem_req), 32'd1);
         check("ld_wait_commit", 32'(commit), 32'd0);
         check("ld_wait_T", 32'(T), 32'd2);
         tick();
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      check("ld_ack_commit", 32'(commit), 32'd1);
      tick();
      check("ld_T0", 32'(T), 32'd0);
      check("ld_instret", instret, 32'd2);

      // Ack in cycle WAIT_LIMIT+1 wins over the timeout.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      check("late_ack_nofault", 32'(fault), 32'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("late_ack_commit", 32'(commit), 32'd1);
      tick();
      check("late_ack_fault", 32'(fault), 32'd0);
      check("late_ack_T", 32'(T), 32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("late_ack_instret", instret, 32'd3);

      // Memory timeout after 16 unacknowledged cycles.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      check("to_not_yet", 32'(fault), 32'd0);
      tick();
      check("to_fault", 32'(fault), 32'd1);
      check("to_cause", 32'(fault_cause), 32'd1);
      check("to_no_req", 32'(mem_req), 32'd0);
      step_go = 1'b1;
      tick();
      step_go = 1'b0;
      check("to_go_ignored", 32'(fault), 32'd1);
      do_reset();
      check("to_rst_fault", 32'(fault), 32'd0);
      check("to_rst_T", 32'(T), 32'd0);
      check("to_rst_cause", 32'(fault_cause), 32'd0);
      check("to_rst_instret", instret, 32'd0);

      // Step overflow: commits at T0..T2 without T_rst.
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check("ovf_T2", 32'(T), 32'd2);
      check("ovf_not_yet", 32'(fault), 32'd0);
      tick();
      check("ovf_fault", 32'(fault), 32'd1);
      check("ovf_cause", 32'(fault_cause), 32'd2);
      check("ovf_T_held", 32'(T), 32'd2);
      check("ovf_commit", 32'(commit), 32'd0);
      do_reset();

      // Debug single-step.
      step_mode = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("ss_paused", 32'(paused), 32'd1);
      check("ss_instret", instret, 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("ss_no_req", 32'(mem_req), 32'd0);
      check("ss_no_commit", 32'(commit), 32'd0);
      tick();
      check("ss_still_paused", 32'(paused), 32'd1);
      check("ss_T0", 32'(T), 32'd0);
      step_go = 1'b1;
      tick();
      step_go = 1'b0;
      #1;
      check("ss_run", 32'(paused), 32'd0);
      check("ss_fetch_req", 32'(mem_req), 32'd1);
      tick();
      check("ss_T1", 32'(T), 32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("ss_repaused", 32'(paused), 32'd1);
      check("ss_instret2", instret, 32'd2);
      step_mode = 1'b0;
      tick();
      check("ss_exit", 32'(paused), 32'd0);

      // hlt together with T_rst.
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check("hlt_halted", 32'(halted), 32'd1);
      check("hlt_instret", instret, 32'd3);
      check("hlt_T", 32'(T), 32'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("hlt_no_req", 32'(mem_req), 32'd0);
      check("hlt_no_commit", 32'(commit), 32'd0);
      tick();
      check("hlt_instret_held", instret, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
